// File: rtl/conv_line_buffer_pkg.sv
// conv_line_buffer_pkg
//   Shared definitions for the convolution row buffer:
//   - default pixel width, maximum kernel height and column address width
//     (the defaults network_para.vh supplies to the front end)
//   - FSM state encoding (IDLE / FILL / STREAM, 2 bits)
//   - lane_lsb(): LSB position of one lane inside the packed
//     DATA_WIDTH*MAX_KERNEL output column
package conv_line_buffer_pkg;

   localparam int LB_DATA_WIDTH_DEF = 8;   // FEATURE_WIDTH
   localparam int LB_MAX_KERNEL_DEF = 5;   // KERNEL_SIZE
   localparam int LB_ADDR_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2
   } lb_state_t;

   function automatic int lane_lsb(input int lane, input int dw);
      return lane * dw;
   endfunction

endpackage

// File: rtl/conv_line_buffer_lb_row_mem.sv
// lb_row_mem
//   One stored image row: 2^ADDR_WIDTH x DATA_WIDTH, asynchronous read,
//   synchronous write. Read and write share one address (the current
//   column), so the read returns the value from before the write.
//   Contents are not reset.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_addr   column address (read and write)
//   i_wdata  write data
//   o_rdata  asynchronous read data at i_addr
module lb_row_mem
   import conv_line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = LB_DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = LB_ADDR_WIDTH_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer
//   Runtime-configurable row buffer. Accepts a raster pixel stream and
//   emits, per accepted pixel, a vertical column of K pixels (lane K-1 is
//   the current pixel, lane k is row r-K+1+k, lanes >= K are zero).
//   Optional build macro CONV_LB_TOP_PAD_EN adds cfg_top_pad: rows above
//   the image are emitted as zero so streaming can start earlier.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_load            pulse: latch cfg_*, abort frame, restart fill
//   cfg_kernel_size     K (2..MAX_KERNEL, otherwise clamped to MAX_KERNEL)
//   cfg_row_len         row length minus 1
//   cfg_top_pad         (CONV_LB_TOP_PAD_EN only) rows of zero padding
//   in_valid/in_ready   input handshake, in_data raster pixel
//   out_valid/out_ready output handshake, out_col column, out_eol last col
//   busy                configured (not IDLE)
//   dbg_state           current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. A producer holds valid and data until the transfer; ready
// may depend combinationally on the other side's ready (in_ready follows
// out_ready in STREAM, there is a single output register and no skid).
module conv_line_buffer
   import conv_line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = LB_DATA_WIDTH_DEF,
   parameter int MAX_KERNEL = LB_MAX_KERNEL_DEF,
   parameter int ADDR_WIDTH = LB_ADDR_WIDTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cfg_load,
   input  logic [2:0]                       cfg_kernel_size,
   input  logic [ADDR_WIDTH-1:0]            cfg_row_len,
`ifdef CONV_LB_TOP_PAD_EN
   input  logic [2:0]                       cfg_top_pad,
`endif
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [DATA_WIDTH-1:0]            in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH*MAX_KERNEL-1:0] out_col,
   output logic                             out_eol,
   output logic                             busy,
   output logic [1:0]                       dbg_state
);

   localparam int                    NMEM    = MAX_KERNEL - 1;
   localparam logic [ADDR_WIDTH-1:0] COL_ONE = ADDR_WIDTH'(1);
   localparam logic [2:0]            ROW_MAX = 3'(MAX_KERNEL - 1);

   lb_state_t                       r_state;
   logic [2:0]                      r_k;
   logic [2:0]                      r_pad;
   logic [2:0]                      r_row;
   logic [ADDR_WIDTH-1:0]           r_len;
   logic [ADDR_WIDTH-1:0]           r_col;
   logic                            r_out_valid;
   logic                            r_out_eol;
   logic [DATA_WIDTH*MAX_KERNEL-1:0] r_out_col;

   logic                            w_accept;
   logic                            w_wrap;
   logic [2:0]                      w_k_lat;
   logic [2:0]                      w_pad_in;
   logic [2:0]                      w_pad_lat;
   logic [2:0]                      w_fill_rows_lat;
   logic [2:0]                      w_fill_rows;
   logic [2:0]                      w_row_next;
   logic [DATA_WIDTH-1:0]           w_rd [NMEM];
   logic [DATA_WIDTH-1:0]           w_wd [NMEM];
   logic [DATA_WIDTH*MAX_KERNEL-1:0] w_col;

`ifdef CONV_LB_TOP_PAD_EN
   assign w_pad_in = cfg_top_pad;
`else
   assign w_pad_in = 3'd0;
`endif

   // Config latch values: illegal K clamps to MAX_KERNEL, pad to K-1.
   always_comb begin
      w_k_lat = cfg_kernel_size;
      if (cfg_kernel_size < 3'd2 || int'(cfg_kernel_size) > MAX_KERNEL) begin
         w_k_lat = 3'(MAX_KERNEL);
      end
      w_pad_lat = w_pad_in;
      if (w_pad_in > w_k_lat - 3'd1) begin
         w_pad_lat = w_k_lat - 3'd1;
      end
      w_fill_rows_lat = w_k_lat - 3'd1 - w_pad_lat;
   end

   assign w_fill_rows = r_k - 3'd1 - r_pad;
   assign w_wrap      = (r_col == r_len);
   assign w_row_next  = (r_row < ROW_MAX) ? r_row + 3'd1 : r_row;

   assign in_ready = (r_state == ST_FILL) ||
                     ((r_state == ST_STREAM) && (!r_out_valid || out_ready));
   // A cfg_load in the same cycle drops the input.
   assign w_accept = in_valid && in_ready && !cfg_load;

   // Row cascade: row 0 takes the new pixel, row j takes old row j-1.
   genvar g;
   generate
      for (g = 0; g < NMEM; g++) begin : g_row
         if (g == 0) begin : g_first
            assign w_wd[g] = in_data;
         end else begin : g_next
            assign w_wd[g] = w_rd[g-1];
         end
         lb_row_mem #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_row_mem (
            .i_clk   (clk),
            .i_we    (w_accept),
            .i_addr  (r_col),
            .i_wdata (w_wd[g]),
            .o_rdata (w_rd[g])
         );
      end
   endgenerate

   // Column assembly: lane K-1 = in_data, lane K-2-j = row memory j.
   // Lanes above the image (k < K-1-row) stay zero; without top padding
   // row >= K-1 whenever this is used, so no lane is ever zeroed.
   always_comb begin
      w_col = '0;
      for (int k = 0; k < MAX_KERNEL; k++) begin
         if (k == int'(r_k) - 1) begin
            w_col[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = in_data;
         end else if (k < int'(r_k) - 1 && k + int'(r_row) >= int'(r_k) - 1) begin
            for (int j = 0; j < NMEM; j++) begin
               if (j == int'(r_k) - 2 - k) begin
                  w_col[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = w_rd[j];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_k         <= 3'd0;
         r_pad       <= 3'd0;
         r_len       <= '0;
         r_col       <= '0;
         r_row       <= 3'd0;
         r_out_valid <= 1'b0;
         r_out_col   <= '0;
         r_out_eol   <= 1'b0;
      end else if (cfg_load) begin
         r_k         <= w_k_lat;
         r_pad       <= w_pad_lat;
         r_len       <= cfg_row_len;
         r_col       <= '0;
         r_row       <= 3'd0;
         r_out_valid <= 1'b0;
         // Full padding leaves nothing to fill.
         r_state     <= (w_fill_rows_lat == 3'd0) ? ST_STREAM : ST_FILL;
      end else begin
         if (w_accept) begin
            r_col <= w_wrap ? '0 : r_col + COL_ONE;
            if (w_wrap) begin
               r_row <= w_row_next;
               if (r_state == ST_FILL && w_row_next >= w_fill_rows) begin
                  r_state <= ST_STREAM;
               end
            end
         end
         if (w_accept && r_state == ST_STREAM) begin
            r_out_valid <= 1'b1;
            r_out_col   <= w_col;
            r_out_eol   <= w_wrap;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_col   = r_out_col;
   assign out_eol   = r_out_eol;
   assign busy      = (r_state != ST_IDLE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_conv_line_buffer.sv
module tb_conv_line_buffer;
   import conv_line_buffer_pkg::*;

   localparam int DW = 8;
   localparam int MK = 5;
   localparam int AW = 8;
   localparam int CW = DW * MK;
   localparam int W  = CW + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_load = 1'b0;
   logic [2:0]    cfg_kernel_size = 3'd0;
   logic [AW-1:0] cfg_row_len = '0;
   logic [2:0]    cfg_top_pad = 3'd0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [CW-1:0] out_col;
   logic          out_eol;
   logic          busy;
   logic [1:0]    dbg_state;

   int checks = 0;
   int passes = 0;
   int n_out  = 0;
   logic [W-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   conv_line_buffer #(
      .DATA_WIDTH (DW),
      .MAX_KERNEL (MK),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cfg_load        (cfg_load),
      .cfg_kernel_size (cfg_kernel_size),
      .cfg_row_len     (cfg_row_len),
`ifdef CONV_LB_TOP_PAD_EN
      .cfg_top_pad     (cfg_top_pad),
`endif
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_col         (out_col),
      .out_eol         (out_eol),
      .busy            (busy),
      .dbg_state       (dbg_state)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [CW-1:0] mk3(input int a, input int b, input int c);
      return {16'h0, 8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [CW-1:0] mk5(input int a, input int b, input int c, input int d, input int e);
      return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_cfg(input logic [2:0] k, input logic [AW-1:0] len, input logic [2:0] pad);
      cfg_load        = 1'b1;
      cfg_kernel_size = k;
      cfg_row_len     = len;
      cfg_top_pad     = pad;
      step();
      cfg_load = 1'b0;
   endtask

   task automatic send_pixel(input int d);
      int t;
      logic acc;
      t   = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'(d);
      while (!acc && t < 64) begin
         @(negedge clk);
         acc = in_ready;
         step();
         t++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         $display("FAIL send_timeout: pixel %0d not accepted within 64 cycles", d);
      end
   endtask

   task automatic drain_and_count(input string name, input int start_cnt, input int exp_cnt);
      repeat (3) step();
      check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      check({name, "_out_count"}, 64'(n_out - start_cnt), 64'(exp_cnt));
      exp_q.delete();
   endtask

   // ---------------- scoreboard ----------------
   // A transfer happens at the next rising edge if valid & ready at negedge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: got col %h eol %b, required none", out_col, out_eol);
         end else begin
            check("out_col_eol", 64'({out_eol, out_col}), 64'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- test ----------------
   typedef struct {
      int   pix;
      logic exp_v;
      int   l0, l1, l2;
      logic eol;
   } vec_t;

   vec_t vt[16];

   initial begin
      int base;
      // K=3, L=4, pixels 1..16: lanes {r-2, r-1, r}
      vt[0]  = '{1,  1'b0, 0, 0, 0,  1'b0};
      vt[1]  = '{2,  1'b0, 0, 0, 0,  1'b0};
      vt[2]  = '{3,  1'b0, 0, 0, 0,  1'b0};
      vt[3]  = '{4,  1'b0, 0, 0, 0,  1'b0};
      vt[4]  = '{5,  1'b0, 0, 0, 0,  1'b0};
      vt[5]  = '{6,  1'b0, 0, 0, 0,  1'b0};
      vt[6]  = '{7,  1'b0, 0, 0, 0,  1'b0};
      vt[7]  = '{8,  1'b0, 0, 0, 0,  1'b0};
      vt[8]  = '{9,  1'b1, 1, 5, 9,  1'b0};
      vt[9]  = '{10, 1'b1, 2, 6, 10, 1'b0};
      vt[10] = '{11, 1'b1, 3, 7, 11, 1'b0};
      vt[11] = '{12, 1'b1, 4, 8, 12, 1'b1};
      vt[12] = '{13, 1'b1, 5, 9, 13, 1'b0};
      vt[13] = '{14, 1'b1, 6, 10, 14, 1'b0};
      vt[14] = '{15, 1'b1, 7, 11, 15, 1'b0};
      vt[15] = '{16, 1'b1, 8, 12, 16, 1'b1};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_col",   64'(out_col),   64'd0);
      check("rst_out_eol",   64'(out_eol),   64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // test 1: K=3, L=4 table
      do_cfg(3'd3, 8'd3, 3'd0);
      @(negedge clk);
      check("t1_busy",  64'(busy),      64'd1);
      check("t1_state", 64'(dbg_state), 64'(ST_FILL));
      step();
      base = n_out;
      for (int i = 0; i < 16; i++) begin
         if (vt[i].exp_v) exp_q.push_back({vt[i].eol, mk3(vt[i].l0, vt[i].l1, vt[i].l2)});
         send_pixel(vt[i].pix);
      end
      drain_and_count("t1", base, 8);

      // test 2: K=5, L=8, first output at pixel 33
      do_cfg(3'd5, 8'd7, 3'd0);
      base = n_out;
      for (int p = 1; p <= 40; p++) begin
         if (p >= 33) exp_q.push_back({(p == 40), mk5(p-32, p-24, p-16, p-8, p)});
         send_pixel(p);
      end
      drain_and_count("t2", base, 8);

      // illegal K=7 clamps to 5; L=2
      do_cfg(3'd7, 8'd1, 3'd0);
      base = n_out;
      for (int p = 1; p <= 10; p++) begin
         if (p >= 9) exp_q.push_back({(p % 2 == 0), mk5(p-8, p-6, p-4, p-2, p)});
         send_pixel(p);
      end
      drain_and_count("clamp", base, 2);

      // test 3: back-pressure for 3 cycles
      do_cfg(3'd3, 8'd3, 3'd0);
      base = n_out;
      for (int p = 1; p <= 8; p++) send_pixel(p);
      out_ready = 1'b0;
      exp_q.push_back({1'b0, mk3(1, 5, 9)});
      send_pixel(9);
      in_valid = 1'b1;
      in_data  = 8'd10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready",  64'(in_ready),  64'd0);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_out_col",   64'(out_col),   64'(mk3(1, 5, 9)));
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int p = 10; p <= 16; p++) begin
         exp_q.push_back({(p % 4 == 0), mk3(p-8, p-4, p)});
         send_pixel(p);
      end
      drain_and_count("t3", base, 8);

      // test 4: cfg_load mid-STREAM, then K=3, L=2
      do_cfg(3'd3, 8'd3, 3'd0);
      base = n_out;
      for (int p = 1; p <= 8; p++) send_pixel(p);
      exp_q.push_back({1'b0, mk3(1, 5, 9)});
      send_pixel(9);
      step();
      out_ready = 1'b0;
      send_pixel(10);
      @(negedge clk);
      check("t4_held_valid", 64'(out_valid), 64'd1);
      step();
      do_cfg(3'd3, 8'd1, 3'd0);
      @(negedge clk);
      check("t4_valid_cleared", 64'(out_valid), 64'd0);
      check("t4_state_fill",    64'(dbg_state), 64'(ST_FILL));
      step();
      out_ready = 1'b1;
      // cfg_load together with a valid input: that input is dropped
      in_valid = 1'b1;
      in_data  = 8'd99;
      do_cfg(3'd3, 8'd1, 3'd0);
      in_valid = 1'b0;
      for (int p = 21; p <= 26; p++) begin
         if (p == 25) exp_q.push_back({1'b0, mk3(21, 23, 25)});
         if (p == 26) exp_q.push_back({1'b1, mk3(22, 24, 26)});
         send_pixel(p);
      end
      drain_and_count("t4", base, 3);

      // test 5: reset during FILL
      do_cfg(3'd3, 8'd3, 3'd0);
      base = n_out;
      for (int p = 1; p <= 3; p++) send_pixel(p);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_out_valid", 64'(out_valid), 64'd0);
      check("t5_out_col",   64'(out_col),   64'd0);
      check("t5_out_eol",   64'(out_eol),   64'd0);
      check("t5_busy",      64'(busy),      64'd0);
      check("t5_state",     64'(dbg_state), 64'(ST_IDLE));
      step();
      in_valid = 1'b1;
      in_data  = 8'd7;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5_in_ready", 64'(in_ready), 64'd0);
         step();
      end
      in_valid = 1'b0;
      drain_and_count("t5", base, 0);

`ifdef CONV_LB_TOP_PAD_EN
      // test 6: K=3, top pad 1, L=4
      do_cfg(3'd3, 8'd3, 3'd1);
      base = n_out;
      for (int p = 1; p <= 12; p++) begin
         if (p >= 5 && p <= 8) exp_q.push_back({(p == 8), mk3(0, p-4, p)});
         if (p >= 9) exp_q.push_back({(p == 12), mk3(p-8, p-4, p)});
         send_pixel(p);
      end
      drain_and_count("t6", base, 8);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
